// File: rtl/iir_acc_sched.sv
// iir_acc_sched
// ---------------------------------------------------------------------------
// Multi-channel running accumulator (y[n] = x[n] + y[n-1] mod 2^width_p)
// with one carry-save adder stage shared between channels. A round-robin
// arbiter picks at most one requesting channel per cycle. Channel state is
// kept redundant (sum_r/carry_r), and only the single result being emitted
// is resolved with a carry-propagate add.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   req_valid    per-channel sample valid
//   req_ready    per-channel accept (combinational, one-hot or zero)
//   req_sample   packed samples, channel i at [i*width_p +: width_p]
//   req_restart  per-channel: an accepted sample restarts the channel (y = x)
//   clr_all      one-cycle pulse: zero every channel through a sweep
//   busy         high while the clear sweep runs
//   out_valid    result valid
//   out_ready    downstream accept
//   out_ch       channel of the result
//   out_sum      resolved accumulator value of out_ch after its update
//   dbg_state    current FSM state (0 = RUN, 1 = CLEAR) for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready never depends on req_sample or req_restart, and
// out_valid never depends on out_ready. Once out_valid is high, out_ch and
// out_sum stay stable until the edge where out_ready is high.
// ---------------------------------------------------------------------------
module iir_acc_sched #(
  parameter int width_p = 16,
  parameter int n_ch_p  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [n_ch_p-1:0]            req_valid,
  output logic [n_ch_p-1:0]            req_ready,
  input  logic [n_ch_p*width_p-1:0]    req_sample,
  input  logic [n_ch_p-1:0]            req_restart,
  input  logic                         clr_all,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(n_ch_p)-1:0]    out_ch,
  output logic [width_p-1:0]           out_sum,
  output logic                         dbg_state
);

  localparam int ch_w = $clog2(n_ch_p);

  localparam logic [0:0] st_run   = 1'b0;
  localparam logic [0:0] st_clear = 1'b1;

  logic [0:0]         state_r;
  logic [ch_w-1:0]    ptr_r;
  logic [ch_w-1:0]    sweep_r;

  // Redundant per-channel state: y = sum_r + (carry_r << 1) mod 2^width_p.
  logic [width_p-1:0] sum_r   [n_ch_p];
  logic [width_p-1:0] carry_r [n_ch_p];

  logic [width_p-1:0] samp [n_ch_p];

  logic               found;
  logic [ch_w-1:0]    win;
  logic [ch_w-1:0]    idx;
  logic               slot_free;
  logic               grant;

  logic [width_p-1:0] csa_x;
  logic [width_p-1:0] csa_a;
  logic [width_p-1:0] csa_b;
  logic [width_p-1:0] csa_sum;
  logic [width_p-1:0] csa_carry;
  logic [width_p-1:0] nxt_sum;
  logic [width_p-1:0] nxt_carry;
  logic [width_p-1:0] nxt_y;

  // Unpack the sample bus so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < n_ch_p; i++) begin
      samp[i] = req_sample[i*width_p +: width_p];
    end
  end

  // Round-robin search starting at ptr_r. The index add wraps naturally
  // because n_ch_p is a power of two.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < n_ch_p; k++) begin
      idx = ptr_r + ch_w'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // The output register can take a new result if it is empty or is being
  // drained on this same edge.
  assign slot_free = !out_valid || out_ready;

  // clr_all wins over any request in the cycle it arrives.
  assign grant = (state_r == st_run) && !clr_all && !rst && slot_free && found;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win] = 1'b1;
    end
  end

  // Shared carry-save stage: three operands (sample, sum, shifted carry)
  // reduced to two without carry propagation.
  always_comb begin
    csa_x     = samp[win];
    csa_a     = sum_r[win];
    csa_b     = carry_r[win] << 1;
    csa_sum   = csa_x ^ csa_a ^ csa_b;
    csa_carry = (csa_x & csa_a) | (csa_x & csa_b) | (csa_a & csa_b);
    if (req_restart[win]) begin
      nxt_sum   = csa_x;
      nxt_carry = '0;
    end else begin
      nxt_sum   = csa_sum;
      nxt_carry = csa_carry;
    end
    // Only the emitted value pays for a full carry-propagate add.
    nxt_y = nxt_sum + (nxt_carry << 1);
  end

  assign busy      = (state_r == st_clear);
  assign dbg_state = state_r[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < n_ch_p; i++) begin
        sum_r[i]   <= '0;
        carry_r[i] <= '0;
      end
      ptr_r     <= '0;
      sweep_r   <= '0;
      state_r   <= st_run;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_sum   <= '0;
    end else begin
      // Datapath and output register. A grant only happens in RUN, so the
      // channel update never collides with the sweep write below.
      if (grant) begin
        sum_r[win]   <= nxt_sum;
        carry_r[win] <= nxt_carry;
        ptr_r        <= win + 1'b1;
        out_valid    <= 1'b1;
        out_ch       <= win;
        out_sum      <= nxt_y;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Control: a pending output keeps draining while the sweep runs.
      case (state_r)
        st_run: begin
          if (clr_all) begin
            state_r <= st_clear;
            sweep_r <= '0;
          end
        end
        st_clear: begin
          sum_r[sweep_r]   <= '0;
          carry_r[sweep_r] <= '0;
          if (sweep_r == ch_w'(n_ch_p - 1)) begin
            state_r <= st_run;
            ptr_r   <= '0;
          end else begin
            sweep_r <= sweep_r + 1'b1;
          end
        end
        default: begin
          state_r <= st_run;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_acc_sched.sv
// Testbench for iir_acc_sched: directed scenarios followed by random traffic,
// checked against a channel-level behavioural model and a result queue.
module tb_iir_acc_sched;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int MASK = (1 << W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_sample;
  logic [N-1:0]    req_restart;
  logic            clr_all;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_ch;
  logic [W-1:0]    out_sum;
  logic            dbg_state;

  iir_acc_sched #(.width_p(W), .n_ch_p(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sample  (req_sample),
    .req_restart (req_restart),
    .clr_all     (clr_all),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_sum     (out_sum),
    .dbg_state   (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  logic [W-1:0]    drv_sample [N];
  int              m_y [N];
  int              m_ptr;
  bit              m_clear;
  int              m_sweep;
  bit              m_ov;
  int              m_och;
  int              m_osum;
  logic [CW+W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_y[i] = 0;
    m_ptr   = 0;
    m_clear = 0;
    m_sweep = 0;
    m_ov    = 0;
    m_och   = 0;
    m_osum  = 0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive at the falling edge, check combinational outputs,
  // advance the model, then check registered outputs just after the rise.
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] rs,
                       input logic clr, input logic ordy, input logic r);
    int g;
    int y;
    logic [N-1:0] er;
    logic [CW+W-1:0] head;
    @(negedge clk);
    req_valid   = v;
    req_restart = rs;
    clr_all     = clr;
    out_ready   = ordy;
    rst         = r;
    for (int i = 0; i < N; i++) req_sample[i*W +: W] = drv_sample[i];
    #1;
    g = -1;
    if (!r && !m_clear && !clr && (!m_ov || ordy)) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && v[c]) g = c;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    check("busy_pre", 32'(busy), 32'(m_clear));
    if (m_ov && ordy) begin
      if (exp_q.size() > 0) begin
        head = exp_q.pop_front();
        check("sb_result", 32'({out_ch, out_sum}), 32'(head));
      end else begin
        check("sb_nonempty", 32'(exp_q.size()), 32'd1);
      end
    end
    if (r) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        if (rs[g]) y = int'(drv_sample[g]);
        else       y = (m_y[g] + int'(drv_sample[g])) & MASK;
        m_y[g] = y;
        m_ov   = 1;
        m_och  = g;
        m_osum = y;
        m_ptr  = (g + 1) % N;
        exp_q.push_back({CW'(g), W'(y)});
      end else if (ordy) begin
        m_ov = 0;
      end
      if (m_clear) begin
        m_y[m_sweep] = 0;
        if (m_sweep == N - 1) begin
          m_clear = 0;
          m_ptr   = 0;
        end else begin
          m_sweep++;
        end
      end else if (clr) begin
        m_clear = 1;
        m_sweep = 0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("busy_post", 32'(busy), 32'(m_clear));
    check("dbg_state", 32'(dbg_state), 32'(m_clear));
    if (m_ov) begin
      check("out_ch", 32'(out_ch), 32'(m_och));
      check("out_sum", 32'(out_sum), 32'(m_osum));
    end
  endtask

  task automatic send(input int ch, input logic [W-1:0] x, input logic rs);
    logic [N-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    drv_sample[ch] = x;
    cycle(v, rs ? v : '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    cycle('0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb;
    int seq [3];
    logic [N-1:0] rv;
    logic [N-1:0] rr;
    seq[0] = 0; seq[1] = 1; seq[2] = 3;

    rst = 1'b1; req_valid = '0; req_restart = '0; clr_all = 1'b0;
    out_ready = 1'b1; req_sample = '0;
    for (int i = 0; i < N; i++) drv_sample[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);

    // Single channel with wrap.
    send(0, 16'd5, 1'b0);      check("s1_sum5", 32'(out_sum), 32'd5);  check("s1_ch", 32'(out_ch), 32'd0);
    send(0, 16'd7, 1'b0);      check("s1_sum12", 32'(out_sum), 32'd12);
    send(0, 16'hFFFF, 1'b0);   check("s1_wrap11", 32'(out_sum), 32'd11);

    // Fairness: all valid, then channel 2 drops out.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < N; c++) drv_sample[c] = W'($urandom_range(0, MASK));
      cycle(4'hF, '0, 1'b0, 1'b1, 1'b0);
      check("fair_order", 32'(out_ch), 32'(i % N));
    end
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < N; c++) drv_sample[c] = W'($urandom_range(0, MASK));
      cycle(4'b1011, '0, 1'b0, 1'b1, 1'b0);
      check("fair_skip", 32'(out_ch), 32'(seq[i % 3]));
    end

    // Backpressure: hold three cycles, then the release cycle grants.
    cycle(4'hF, '0, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(4'hF, '0, 1'b0, 1'b0, 1'b0);
    cycle(4'hF, '0, 1'b0, 1'b1, 1'b0);
    check("bp_release_ch", 32'(out_ch), 32'd1);

    // Restart.
    do_reset();
    send(2, 16'd100, 1'b0);    check("rs_100", 32'(out_sum), 32'd100);
    send(2, 16'd9, 1'b1);      check("rs_9", 32'(out_sum), 32'd9);
    send(2, 16'd1, 1'b0);      check("rs_10", 32'(out_sum), 32'd10);

    // Clear sweep while channel 1 holds 50.
    do_reset();
    send(1, 16'd50, 1'b0);     check("clr_50", 32'(out_sum), 32'd50);
    nb = 0;
    cycle('0, '0, 1'b1, 1'b1, 1'b0);
    if (busy) nb++;
    for (int i = 0; i < 4; i++) begin
      cycle(4'hF, '0, (i == 1), 1'b1, 1'b0);
      if (busy) nb++;
    end
    cycle('0, '0, 1'b0, 1'b1, 1'b0);
    if (busy) nb++;
    check("clr_busy_cycles", 32'(nb), 32'd4);
    send(1, 16'd3, 1'b0);      check("clr_after", 32'(out_sum), 32'd3);

    // Reset in the middle of a sweep with an output held.
    send(3, 16'd20, 1'b0);
    cycle('0, '0, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle(4'hF, '0, 1'b0, 1'b0, 1'b0);
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ov", 32'(out_valid), 32'd0);
    send(3, 16'd4, 1'b0);      check("rstmid_ch3", 32'(out_sum), 32'd4);
    send(1, 16'd6, 1'b0);      check("rstmid_ch1", 32'(out_sum), 32'd6);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < N; c++) begin
        drv_sample[c] = W'($urandom_range(0, MASK));
        rr[c] = ($urandom_range(0, 7) == 0);
      end
      rv = N'($urandom_range(0, (1 << N) - 1));
      cycle(rv, rr, ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 99) == 0));
    end
    repeat (2) cycle('0, '0, 1'b0, 1'b1, 1'b0);
    check("sb_left", 32'(exp_q.size()), 32'(m_ov));

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_acc_sched.md
IIR_ACC_SCHED -- requirements
Module: iir_acc_sched

Interface
REQ-001 SHALL have parameter width_p, default 16: sample and accumulator width in bits.
REQ-002 SHALL have parameter n_ch_p, default 4: number of requesters (channels), a power of two, 2 to 16.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, n_ch_p: per-channel sample valid.
REQ-006 SHALL have port req_ready, output, n_ch_p: per-channel grant/accept, combinational.
REQ-007 SHALL have port req_sample, input, n_ch_p*width_p: channel i sample at bits [i*width_p +: width_p].
REQ-008 SHALL have port req_restart, input, n_ch_p: when set with an accepted sample, the channel restarts (y = x) instead of accumulating.
REQ-009 SHALL have port clr_all, input, 1: one-cycle pulse; zeroes every channel accumulator.
REQ-010 SHALL have port busy, output, 1: high while the CLEAR sweep runs.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accept.
REQ-013 SHALL have port out_ch, output, log2(n_ch_p): channel of the result.
REQ-014 SHALL have port out_sum, output, width_p: resolved accumulator value y[n] of out_ch.

Function
REQ-015 SHALL keep per-channel state in carry-save form (sum_r[i], carry_r[i], each width_p); resolved value y = (sum_r + (carry_r << 1)) mod 2^width_p.
REQ-016 SHALL time-share one carry-save adder stage across channels; the granted channel's state is updated via CSA(x, sum_r, carry_r << 1), or set to sum = x, carry = 0 when req_restart[i] is set.
REQ-017 SHALL implement y[n] = x[n] + y[n-1] per channel, modulo 2^width_p, wrapping silently with no overflow flag.
REQ-018 SHALL grant at most one channel per cycle, by round-robin.
- Priority pointer ptr resets to 0.
- The search starts at ptr and increments modulo n_ch_p; the first channel with req_valid set wins.
- After a grant to channel g, ptr becomes (g+1) mod n_ch_p; with no grant, ptr holds.
REQ-019 SHALL assert req_ready[g] only for the winner, and only when the FSM is RUN and the output slot is free (out_valid = 0, or out_valid = 1 and out_ready = 1 in the same cycle).
REQ-020 SHALL, for a handshake on channel g at edge k, present out_valid = 1, out_ch = g and out_sum = the new y of g from edge k (one-cycle latency).
REQ-021 SHALL hold out_valid, out_ch and out_sum stable while out_valid = 1 and out_ready = 0, and clear out_valid after acceptance if no new grant occurs.
REQ-022 SHALL sustain one result per cycle when out_ready is held high.
REQ-023 SHALL implement a 2-state FSM, RUN and CLEAR.
- RUN to CLEAR: on clr_all = 1. The sweep index is set to 0 and no grant is made that cycle.
- CLEAR: one channel is zeroed per cycle (index 0 to n_ch_p-1); busy = 1; all req_ready = 0.
- CLEAR to RUN: after channel n_ch_p-1 is zeroed, i.e. after n_ch_p cycles in CLEAR; ptr resets to 0.
REQ-024 SHALL ignore clr_all while in CLEAR.
REQ-025 SHALL let a pending output already in out_valid drain normally during CLEAR; its value is not altered.
REQ-026 SHALL give clr_all priority over a simultaneous req_valid; no sample is accepted in that cycle.
REQ-027 SHALL never alter the state of a non-granted channel, except during CLEAR sweep zeroing.

Reset
REQ-028 SHALL, while rst = 1 at a clock edge, set all sum_r and carry_r to 0, ptr = 0, FSM = RUN, out_valid = 0, out_ch = 0, out_sum = 0 and busy = 0.
REQ-029 SHALL, while rst = 1, drive req_ready = 0.
REQ-030 SHALL let rst abort a CLEAR sweep or a held output; the block is in REQ-028 state at the first edge after rst deasserts.

Verification
REQ-031 SHALL cover a single channel: width 16, ch0 samples 5, 7, 0xFFFF with out_ready = 1 -> out_sum 5, 12, 11 (wrap) on consecutive cycles, each with out_ch = 0.
REQ-032 SHALL cover fairness: all 4 channels valid continuously -> grant order 0, 1, 2, 3, 0, 1, ..., one per cycle; a channel dropping valid is skipped.
REQ-033 SHALL cover backpressure: out_ready = 0 for 3 cycles after a result -> out_* held constant, req_ready all 0, no channel state changes; release -> the next grant occurs that cycle.
REQ-034 SHALL cover restart: ch2 holds y = 100; a sample of 9 with req_restart[2] = 1 -> out_sum 9; the next sample of 1 -> 10.
REQ-035 SHALL cover clear: clr_all pulsed while ch1 holds y = 50 -> busy high exactly 4 cycles, req_ready 0 throughout; the next ch1 sample of 3 -> out_sum 3.
REQ-036 SHALL cover reset mid-sweep: rst asserted during CLEAR -> busy = 0 and out_valid = 0 after the edge; all channels then accumulate from 0.
